conv_feeder: RTL and testbench
==============================

CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, giving the width of feature/output memory addresses and of len.
REQ-002 SHALL use the team define `DATA_BITS for data widths; RW below denotes `DATA_BITS*2+2.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to run one 1-D 3-tap convolution pass.
REQ-006 len  in  ADDR_BITS  number of input features; sampled on the edge that accepts start.
REQ-007 busy  out  1  high in every state except IDLE and DONE.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 w_addr  out  2  weight memory read address, weights at 0..2.
REQ-010 w_rdata  in  `DATA_BITS  weight memory data, valid one cycle after w_addr.
REQ-011 if_addr  out  ADDR_BITS  feature memory read address.
REQ-012 if_rdata  in  `DATA_BITS  feature memory data, valid one cycle after if_addr.
REQ-013 clear  out  1  synchronous clear strobe to the Conv PE.
REQ-014 w_w / w_in  out  1 / `DATA_BITS  weight shift-in strobe and data to the Conv PE.
REQ-015 if_w / if_in  out  1 / `DATA_BITS  feature shift-in strobe and data to the Conv PE.
REQ-016 result  in  RW  Conv PE dot product; reflects PE registers after the last write edge.
REQ-017 out_we / out_addr / out_data  out  1 / ADDR_BITS / RW  output memory write port.

Function
REQ-018 SHALL implement the FSM IDLE -> CLR -> LW -> LF -> WAIT -> DONE -> IDLE.
REQ-019 IDLE: start=1 with len>=3 SHALL go to CLR; start=1 with len<3 SHALL go directly to DONE with no PE or memory writes.
REQ-020 start while not in IDLE SHALL be ignored.
REQ-021 CLR: SHALL last exactly 1 cycle with clear=1; clear SHALL be 0 in all other states.
REQ-022 LW: SHALL last 4 cycles; w_addr=0,1,2 in cycles 1-3; w_w=1 in cycles 2-4; w_in driven combinationally from w_rdata.
REQ-023 LF: SHALL last len cycles, issuing if_addr=0..len-1, one per cycle.
REQ-024 if_w SHALL be high in the cycle after each if_addr issue, with if_in driven combinationally from if_rdata; if_w is never high outside those cycles.
REQ-025 Window alignment: the first-written weight pairs with the oldest feature; output j = w0*f[j] + w1*f[j+1] + w2*f[j+2] (signed).
REQ-026 For feature k>=2 written via if_w in cycle c, SHALL register result into out_data at the end of cycle c+1, with out_we=1 and out_addr=k-2 in cycle c+2.
REQ-027 Exactly len-2 output writes per pass, addresses 0..len-3, ascending, no gaps or duplicates.
REQ-028 WAIT: SHALL last 3 cycles covering the final if_w, the capture and the final out_we; then DONE.
REQ-029 DONE: SHALL last 1 cycle with done=1 and busy=0; then IDLE.
REQ-030 For len=N>=3, with cycle 1 as the CLR cycle after the start-sampling edge, done SHALL be high in cycle N+9.
REQ-031 out_data SHALL pass result through without truncation or re-extension.
REQ-032 len=2^ADDR_BITS-1 (maximum) SHALL run without address wrap.

Reset
REQ-033 rst low SHALL immediately force IDLE, with busy, done, clear, w_w, if_w, out_we=0 and all address/data outputs=0, regardless of state.
REQ-034 After rst release, SHALL wait for a new start; an interrupted pass SHALL NOT resume and SHALL issue no further writes.

Verification
REQ-035 Weights 1,2,3; features 1..5; len=5 -> out mem[0..2]=14,20,26; done in cycle 14.
REQ-036 Weights -1,0,1; features 10,20,30; len=3 -> single write mem[0]=20; done in cycle 12.
REQ-037 len=2 with start -> done in next cycle, no clear/w_w/if_w/out_we ever asserted.
REQ-038 start re-pulsed mid-LF -> ignored; write count and values identical to the undisturbed run.
REQ-039 rst low during LF of len=8 -> all strobes 0 same cycle; after release, a fresh len=4 run gives 2 correct writes only.
REQ-040 Weights -128 x3, features -128 x3 (DATA_BITS=8) -> mem[0]=49152, no overflow in RW bits.

Source files
------------

// File: rtl/conv_feeder.sv
// Sequencer for a 1-D 3-tap convolution: loads three weights and streams features into the Conv PE.
// It then writes one PE result per complete window to the output memory.
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | one-cycle clear of the PE registers
//   LW    | weight fetch (3 reads) and shift-in (3 writes)
//   LF    | feature address issue, one per cycle
//   WAIT  | drain: last feature write, last capture, last output write
//   DONE  | one-cycle completion pulse
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module conv_feeder #(
  parameter int ADDR_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_BITS-1:0]       len,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 w_addr,
  input  logic [`DATA_BITS-1:0]      w_rdata,
  output logic [ADDR_BITS-1:0]       if_addr,
  input  logic [`DATA_BITS-1:0]      if_rdata,
  output logic                       clear,
  output logic                       w_w,
  output logic [`DATA_BITS-1:0]      w_in,
  output logic                       if_w,
  output logic [`DATA_BITS-1:0]      if_in,
  input  logic [`DATA_BITS*2+1:0]    result,
  output logic                       out_we,
  output logic [ADDR_BITS-1:0]       out_addr,
  output logic [`DATA_BITS*2+1:0]    out_data
);

  localparam int RW = `DATA_BITS * 2 + 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_LW   = 3'd2;
  localparam logic [2:0] S_LF   = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] len_q, len_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] faddr_q, faddr_d;
  logic                 ww_q, ww_d;
  logic                 fw_q, fw_d;
  logic [ADDR_BITS-1:0] fidx_q, fidx_d;
  logic                 cap_q, cap_d;
  logic [ADDR_BITS-1:0] cap_addr_q, cap_addr_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] oaddr_q, oaddr_d;
  logic [RW-1:0]        odata_q, odata_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    faddr_d    = faddr_q;
    fidx_d     = fidx_q;
    ww_d       = 1'b0;
    fw_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          state_d = (len >= ADDR_BITS'(3)) ? S_CLR : S_DONE;
        end
      end
      S_CLR: begin
        cnt_d   = 2'd3;
        faddr_d = '0;
        state_d = S_LW;
      end
      S_LW: begin
        // cnt 3..1 issue weight reads; the write strobe trails each read by one cycle
        ww_d = (cnt_q != 2'd0);
        if (cnt_q == 2'd0) begin
          state_d = S_LF;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_LF: begin
        fw_d   = 1'b1;
        fidx_d = faddr_q;
        if (faddr_q == len_q - ADDR_BITS'(1)) begin
          cnt_d   = 2'd2;
          state_d = S_WAIT;
        end else begin
          faddr_d = faddr_q + ADDR_BITS'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result pipeline: feature write -> capture of PE result -> output memory write.
  always_comb begin
    cap_d      = fw_q && (fidx_q >= ADDR_BITS'(2));
    cap_addr_d = fidx_q - ADDR_BITS'(2);
    we_d       = cap_q;
    oaddr_d    = oaddr_q;
    odata_d    = odata_q;
    if (cap_q) begin
      oaddr_d = cap_addr_q;
      odata_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      faddr_q    <= '0;
      ww_q       <= 1'b0;
      fw_q       <= 1'b0;
      fidx_q     <= '0;
      cap_q      <= 1'b0;
      cap_addr_q <= '0;
      we_q       <= 1'b0;
      oaddr_q    <= '0;
      odata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      faddr_q    <= faddr_d;
      ww_q       <= ww_d;
      fw_q       <= fw_d;
      fidx_q     <= fidx_d;
      cap_q      <= cap_d;
      cap_addr_q <= cap_addr_d;
      we_q       <= we_d;
      oaddr_q    <= oaddr_d;
      odata_q    <= odata_d;
    end
  end

  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
    clear    = (state_q == S_CLR);
    w_addr   = ((state_q == S_LW) && (cnt_q != 2'd0)) ? (2'd3 - cnt_q) : 2'd0;
    if_addr  = (state_q == S_LF) ? faddr_q : '0;
    w_w      = ww_q;
    w_in     = ww_q ? w_rdata : '0;
    if_w     = fw_q;
    if_in    = fw_q ? if_rdata : '0;
    out_we   = we_q;
    out_addr = oaddr_q;
    out_data = odata_q;
  end

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder: memory and Conv PE models around the DUT, scoreboard of expected output writes.
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module tb_conv_feeder;
  localparam int AB = 8;
  localparam int DB = `DATA_BITS;
  localparam int RW = DB * 2 + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] len = '0;
  logic          busy, done, clear, w_w, if_w, out_we;
  logic [1:0]    w_addr;
  logic [DB-1:0] w_rdata, if_rdata, w_in, if_in;
  logic [AB-1:0] if_addr, out_addr;
  logic [RW-1:0] result, out_data;

  conv_feeder #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .w_addr(w_addr), .w_rdata(w_rdata), .if_addr(if_addr), .if_rdata(if_rdata),
    .clear(clear), .w_w(w_w), .w_in(w_in), .if_w(if_w), .if_in(if_in),
    .result(result), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  logic [DB-1:0] wmem [4];
  logic [DB-1:0] fmem [256];

  always @(posedge clk) begin
    w_rdata  <= wmem[w_addr];
    if_rdata <= fmem[if_addr];
  end

  // Conv PE model: shift registers, oldest entry in slot 0.
  logic signed [DB-1:0] wr [3];
  logic signed [DB-1:0] fr [3];
  always @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 3; i++) begin
        wr[i] <= '0;
        fr[i] <= '0;
      end
    end else begin
      if (w_w) begin
        wr[0] <= wr[1]; wr[1] <= wr[2]; wr[2] <= w_in;
      end
      if (if_w) begin
        fr[0] <= fr[1]; fr[1] <= fr[2]; fr[2] <= if_in;
      end
    end
  end
  always_comb begin
    int acc;
    acc = 0;
    for (int i = 0; i < 3; i++) acc += int'(wr[i]) * int'(fr[i]);
    result = acc[RW-1:0];
  end

  int errs = 0;
  int checks = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int clr_cnt = 0, ww_cnt = 0, ifw_cnt = 0, we_cnt = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Every wait goes through here so strobes and output writes are never missed.
  task automatic tick();
    int ea, ed;
    @(negedge clk);
    if (clear) clr_cnt++;
    if (w_w) ww_cnt++;
    if (if_w) ifw_cnt++;
    if (out_we) begin
      we_cnt++;
      chk("we_expected", int'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        chk("out_addr", int'(out_addr), ea);
        chk("out_data", int'($signed(out_data)), ed);
      end
    end
  endtask

  function automatic int conv_ref(int j);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++) s += int'($signed(wmem[i])) * int'($signed(fmem[j + i]));
    return s;
  endfunction

  task automatic outs_zero(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_clear"}, int'(clear), 0);
    chk({nm, "_w_w"}, int'(w_w), 0);
    chk({nm, "_if_w"}, int'(if_w), 0);
    chk({nm, "_out_we"}, int'(out_we), 0);
    chk({nm, "_w_addr"}, int'(w_addr), 0);
    chk({nm, "_if_addr"}, int'(if_addr), 0);
    chk({nm, "_out_addr"}, int'(out_addr), 0);
    chk({nm, "_out_data"}, int'(out_data), 0);
  endtask

  task automatic launch(input int n);
    for (int j = 0; j + 2 < n; j++) begin
      exp_addr_q.push_back(j);
      exp_data_q.push_back(conv_ref(j));
    end
    start = 1'b1;
    len   = AB'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic do_pass(input string nm, input int n, input int pulse_cyc);
    int c0, w0, f0, e0, dc, cyc;
    c0 = clr_cnt; w0 = ww_cnt; f0 = ifw_cnt; e0 = we_cnt;
    launch(n);
    cyc = 1;
    dc = -1;
    while (cyc <= n + 40) begin
      if (done) begin
        dc = cyc;
        chk({nm, "_busy_at_done"}, int'(busy), 0);
        break;
      end
      start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) len = AB'(3);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_done_cyc"}, dc, (n < 3) ? 1 : n + 9);
    repeat (4) tick();
    chk({nm, "_idle_busy"}, int'(busy), 0);
    chk({nm, "_clear_cnt"}, clr_cnt - c0, (n < 3) ? 0 : 1);
    chk({nm, "_ww_cnt"}, ww_cnt - w0, (n < 3) ? 0 : 3);
    chk({nm, "_ifw_cnt"}, ifw_cnt - f0, (n < 3) ? 0 : n);
    chk({nm, "_we_cnt"}, we_cnt - e0, (n < 3) ? 0 : n - 2);
    chk({nm, "_sb_left"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    int e0, c0;
    for (int i = 0; i < 4; i++) wmem[i] = '0;
    for (int i = 0; i < 256; i++) fmem[i] = '0;
    #12;
    outs_zero("rst");
    #10;
    rst = 1'b1;
    repeat (2) tick();

    // 1,2,3 over 1..5
    wmem[0] = 8'd1; wmem[1] = 8'd2; wmem[2] = 8'd3;
    for (int i = 0; i < 5; i++) fmem[i] = DB'(i + 1);
    chk("ref_len5_j0", conv_ref(0), 14);
    do_pass("len5", 5, 0);

    // -1,0,1 over 10,20,30
    wmem[0] = 8'hFF; wmem[1] = 8'd0; wmem[2] = 8'd1;
    fmem[0] = 8'd10; fmem[1] = 8'd20; fmem[2] = 8'd30;
    chk("ref_len3_j0", conv_ref(0), 20);
    do_pass("len3", 3, 0);

    do_pass("len2", 2, 0);
    do_pass("len0", 0, 0);

    // start re-pulsed while streaming features
    wmem[0] = 8'd1; wmem[1] = 8'd2; wmem[2] = 8'd3;
    for (int i = 0; i < 5; i++) fmem[i] = DB'(i + 1);
    do_pass("restart", 5, 8);

    // reset during LF of len=8, after two writes have landed
    wmem[0] = 8'd2; wmem[1] = 8'hFD; wmem[2] = 8'd5;
    for (int i = 0; i < 8; i++) fmem[i] = DB'(i * 7 + 3);
    e0 = we_cnt;
    launch(8);
    repeat (11) tick();
    chk("irq_we_before", we_cnt - e0, 2);
    chk("irq_in_lf_if_w", int'(if_w), 1);
    #2 rst = 1'b0;
    #1;
    outs_zero("irq");
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) tick();
    #2 rst = 1'b1;
    e0 = we_cnt;
    c0 = clr_cnt;
    repeat (12) tick();
    chk("irq_no_resume_we", we_cnt - e0, 0);
    chk("irq_no_resume_clr", clr_cnt - c0, 0);
    chk("irq_no_resume_busy", int'(busy), 0);
    wmem[0] = 8'd1; wmem[1] = 8'd1; wmem[2] = 8'hFE;
    for (int i = 0; i < 4; i++) fmem[i] = DB'(i + 9);
    do_pass("after_rst_len4", 4, 0);

    // extreme magnitudes
    for (int i = 0; i < 3; i++) begin
      wmem[i] = 8'h80;
      fmem[i] = 8'h80;
    end
    chk("ref_neg128", conv_ref(0), 49152);
    do_pass("neg128", 3, 0);

    // maximum length, random data
    for (int i = 0; i < 3; i++) wmem[i] = DB'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) fmem[i] = DB'($urandom_range(0, 255));
    do_pass("max_len", 255, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
